// File: rtl/shd_chain_driver.sv
// shd_chain_driver: streams segment bytes into chained SHD0028 boards with load handshake, blink and PWM dimming
module shd_chain_driver #(
    parameter int N_DIGITS  = 6,
    parameter int CLK_DIV   = 2,
    parameter int MSB_FIRST = 0,
    parameter int LATCH_GAP = 4,
    parameter int BLINK_DIV = 0,
    parameter int PWM_BITS  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [8*N_DIGITS-1:0] SEG_DATA,
    input  logic [N_DIGITS-1:0]   BLINK_MASK,
    input  logic                  SEG_VALID,
    output logic                  SEG_READY,
    input  logic [PWM_BITS-1:0]   BRIGHTNESS,
    output logic                  SHD_DATA,
    output logic                  SHD_CLK,
    output logic                  SHD_LATCH,
    output logic                  SHD_ENABLE_n,
    output logic                  FRAME_DONE
);
    localparam int FW = 8 * N_DIGITS;
    localparam int DW = $clog2(CLK_DIV);
    localparam int CW = $clog2(FW + LATCH_GAP + 1);
    localparam int KW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF   = DW'(CLK_DIV / 2);
    localparam logic [CW-1:0] BIT_LAST   = CW'(FW - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(LATCH_GAP - 1);
    localparam logic [KW-1:0] BLINK_LAST = KW'(BLINK_DIV > 0 ? BLINK_DIV - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, GAP} state_t;

    state_t              state, state_nxt;
    logic [DW-1:0]       div_cnt, div_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [FW-1:0]       pend_data, disp_data, src_data, masked, ordered, sreg, sreg_nxt;
    logic [N_DIGITS-1:0] pend_mask, disp_mask, src_mask;
    logic [KW-1:0]       blink_cnt, blink_nxt;
    logic [PWM_BITS-1:0] pwm_cnt, pwm_nxt;
    logic                tick, toggle, phase, phase_nxt, refresh, start, consume, data_nxt;

    // serial-period divider, blink timebase and PWM counter next values
    always_comb begin
        tick      = div_cnt == DIV_LAST;
        div_nxt   = tick ? '0 : div_cnt + 1'b1;
        toggle    = BLINK_DIV > 0 && tick && blink_cnt == BLINK_LAST;
        blink_nxt = (BLINK_DIV == 0 || toggle) ? '0 : tick ? blink_cnt + 1'b1 : blink_cnt;
        phase_nxt = toggle ? !phase : phase;
        pwm_nxt   = tick ? pwm_cnt + 1'b1 : pwm_cnt;
    end

    // frame image: pending data wins over displayed, blanked digits use the phase in force after this tick
    always_comb begin
        src_data = SEG_READY ? disp_data : pend_data;
        src_mask = SEG_READY ? disp_mask : pend_mask;
        masked   = src_data;
        ordered  = '0;
        for (int k = 0; k < N_DIGITS; k++)
            if (!phase_nxt && src_mask[k]) masked[8*k +: 8] = 8'h00;
        for (int i = 0; i < FW; i++)
            ordered[i] = MSB_FIRST != 0 ? masked[FW-1-i] : masked[i];
    end

    // FSM next state and serial data; everything advances only on tick
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        data_nxt  = SHD_DATA;
        consume   = tick && state == IDLE && !SEG_READY;
        start     = tick && state == IDLE && (!SEG_READY || refresh);
        if (tick)
            case (state)
                IDLE: if (start) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    data_nxt  = ordered[0];
                    sreg_nxt  = ordered >> 1;
                end
                SHIFT: if (cnt == BIT_LAST) begin
                    state_nxt = LATCH;
                    cnt_nxt   = '0;
                    data_nxt  = 1'b0;
                end else begin
                    cnt_nxt  = cnt + 1'b1;
                    data_nxt = sreg[0];
                    sreg_nxt = sreg >> 1;
                end
                LATCH: state_nxt = GAP;
                GAP: begin
                    state_nxt = cnt == GAP_LAST ? IDLE : GAP;
                    cnt_nxt   = cnt == GAP_LAST ? '0 : cnt + 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
    end

    // FSM state, shift register and registered pin outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            div_cnt      <= '0;
            cnt          <= '0;
            sreg         <= '0;
            pwm_cnt      <= '0;
            SHD_DATA     <= 1'b0;
            SHD_CLK      <= 1'b0;
            SHD_LATCH    <= 1'b0;
            SHD_ENABLE_n <= 1'b1;
            FRAME_DONE   <= 1'b0;
        end else begin
            state        <= state_nxt;
            div_cnt      <= div_nxt;
            cnt          <= cnt_nxt;
            sreg         <= sreg_nxt;
            pwm_cnt      <= pwm_nxt;
            SHD_DATA     <= data_nxt;
            SHD_CLK      <= state_nxt == SHIFT && div_nxt >= DIV_HALF;
            SHD_LATCH    <= state_nxt == LATCH;
            SHD_ENABLE_n <= &BRIGHTNESS ? 1'b0 : !(pwm_nxt < BRIGHTNESS);
            FRAME_DONE   <= tick && state == LATCH;
        end
    end

    // one-entry pending buffer; it empties into the displayed image when a frame starts from it
    always_ff @(posedge CLK) begin
        if (RST) begin
            SEG_READY <= 1'b1;
            pend_data <= '0;
            pend_mask <= '0;
            disp_data <= '0;
            disp_mask <= '0;
        end else begin
            if (SEG_VALID && SEG_READY) begin
                pend_data <= SEG_DATA;
                pend_mask <= BLINK_MASK;
                SEG_READY <= 1'b0;
            end else if (consume) begin
                SEG_READY <= 1'b1;
            end
            if (consume) begin
                disp_data <= pend_data;
                disp_mask <= pend_mask;
            end
        end
    end

    // blink phase; a toggle requests a refresh unless a frame starts on the same tick
    always_ff @(posedge CLK) begin
        if (RST) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
            refresh   <= 1'b0;
        end else begin
            blink_cnt <= blink_nxt;
            phase     <= phase_nxt;
            refresh   <= start ? 1'b0 : toggle ? 1'b1 : refresh;
        end
    end
endmodule

// File: tb/tb_shd_chain_driver.sv
// tb_shd_chain_driver: directed checks of framing, handshake, bit order, blink, PWM and reset abort
module tb_shd_chain_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_b = 1'b1;
    logic [47:0] sdat [3];
    logic [5:0]  bm [3];
    logic        vld [3];
    logic [3:0]  bright [3];
    logic        rdy [3], sd [3], sc [3], sl [3], se [3], fd [3];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nb [3] = '{0, 0, 0};
    int ndone [3] = '{0, 0, 0};
    int nlat [3] = '{0, 0, 0};
    int done_cyc [3] = '{0, 0, 0};
    logic pc [3] = '{1'b0, 1'b0, 1'b0};
    logic bitlog [3][1024];
    int rise_cyc [3][1024];

    shd_chain_driver u0 (.CLK(clk), .RST(rst), .SEG_DATA(sdat[0]), .BLINK_MASK(bm[0]), .SEG_VALID(vld[0]),
        .SEG_READY(rdy[0]), .BRIGHTNESS(bright[0]), .SHD_DATA(sd[0]), .SHD_CLK(sc[0]), .SHD_LATCH(sl[0]),
        .SHD_ENABLE_n(se[0]), .FRAME_DONE(fd[0]));
    shd_chain_driver #(.MSB_FIRST(1)) u1 (.CLK(clk), .RST(rst), .SEG_DATA(sdat[1]), .BLINK_MASK(bm[1]),
        .SEG_VALID(vld[1]), .SEG_READY(rdy[1]), .BRIGHTNESS(bright[1]), .SHD_DATA(sd[1]), .SHD_CLK(sc[1]),
        .SHD_LATCH(sl[1]), .SHD_ENABLE_n(se[1]), .FRAME_DONE(fd[1]));
    shd_chain_driver #(.BLINK_DIV(120)) u2 (.CLK(clk), .RST(rst_b), .SEG_DATA(sdat[2]), .BLINK_MASK(bm[2]),
        .SEG_VALID(vld[2]), .SEG_READY(rdy[2]), .BRIGHTNESS(bright[2]), .SHD_DATA(sd[2]), .SHD_CLK(sc[2]),
        .SHD_LATCH(sl[2]), .SHD_ENABLE_n(se[2]), .FRAME_DONE(fd[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // record the data bit at every serial clock rise, plus latch cycles and frame-done pulses
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (sc[i] && !pc[i]) begin
                bitlog[i][nb[i] & 1023] = sd[i];
                rise_cyc[i][nb[i] & 1023] = cyc;
                nb[i] = nb[i] + 1;
            end
            pc[i] = sc[i];
            if (sl[i]) nlat[i] = nlat[i] + 1;
            if (fd[i]) begin
                ndone[i] = ndone[i] + 1;
                done_cyc[i] = cyc;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] word(input int i, input int base, input int n);
        logic [47:0] w = '0;
        for (int k = 0; k < n; k++) w[k] = bitlog[i][(base + k) & 1023];
        return w;
    endfunction

    task automatic load(input int i, input logic [47:0] d, input logic [5:0] m);
        sdat[i] = d;
        bm[i] = m;
        vld[i] = 1'b1;
        step();
        vld[i] = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int i, input int target, input int limit);
        int n = 0;
        while (ndone[i] < target && n < limit) begin
            step();
            n++;
        end
        chk(tag, 64'(ndone[i] >= target), 64'd1);
    endtask

    initial begin
        int base, d, l, hi, lo;
        for (int i = 0; i < 3; i++) begin
            sdat[i] = '0;
            bm[i] = '0;
            vld[i] = 1'b0;
            bright[i] = 4'hF;
        end
        step();
        step();
        chk("reset_outputs", 64'({sd[0], sc[0], sl[0], se[0], fd[0], rdy[0]}), 64'b000101);
        rst = 1'b0;
        step();

        base = nb[0];
        d = ndone[0];
        l = nlat[0];
        load(0, 48'h0000_0000_00FC, 6'd0);
        wait_done("f1_timeout", 0, d + 1, 400);
        repeat (20) step();
        chk("f1_word", 64'(word(0, base, 48)), 64'h0000_0000_00FC);
        chk("f1_rises", 64'(nb[0] - base), 64'd48);
        chk("f1_latch_cycles", 64'(nlat[0] - l), 64'd2);
        chk("f1_done_pulses", 64'(ndone[0] - d), 64'd1);
        chk("f1_rise_to_done", 64'(done_cyc[0] - rise_cyc[0][base & 1023]), 64'd97);
        chk("f1_ready", 64'(rdy[0]), 64'd1);

        load(1, 48'h8000_0000_0000, 6'd0);
        wait_done("msb_timeout", 1, 1, 400);
        chk("msb_word", 64'(word(1, 0, 48)), 64'h1);
        chk("msb_rises", 64'(nb[1]), 64'd48);

        base = nb[0];
        d = ndone[0];
        load(0, 48'h0123_4567_89AB, 6'd0);
        repeat (12) step();
        sdat[0] = 48'h0BAD_CAFE_1234;
        vld[0] = 1'b1;
        hi = 0;
        repeat (6) begin
            if (rdy[0]) hi++;
            step();
        end
        sdat[0] = 48'h00C0_C0C0_C0C0;
        lo = 0;
        repeat (20) begin
            if (rdy[0]) lo++;
            step();
        end
        vld[0] = 1'b0;
        chk("b_ready_cycles", 64'(hi), 64'd1);
        chk("c_ready_cycles", 64'(lo), 64'd0);
        wait_done("ab_timeout", 0, d + 2, 600);
        repeat (300) step();
        chk("a_word", 64'(word(0, base, 48)), 64'h0123_4567_89AB);
        chk("b_word", 64'(word(0, base + 48, 48)), 64'h0BAD_CAFE_1234);
        chk("ab_frames", 64'(ndone[0] - d), 64'd2);
        chk("ab_rises", 64'(nb[0] - base), 64'd96);
        chk("ab_ready", 64'(rdy[0]), 64'd1);

        for (int k = 0; k < 3; k++) begin
            bright[0] = k == 0 ? 4'd0 : k == 1 ? 4'd4 : 4'd15;
            repeat (4) step();
            lo = 0;
            repeat (32) begin
                if (!se[0]) lo++;
                step();
            end
            chk("pwm_low_cycles", 64'(lo), k == 0 ? 64'd0 : k == 1 ? 64'd8 : 64'd32);
        end
        bright[0] = 4'hF;

        base = nb[0];
        d = ndone[0];
        l = nlat[0];
        load(0, 48'h1122_3344_5566, 6'd0);
        repeat (4) step();
        load(0, 48'h7777_7777_7777, 6'd0);
        hi = 0;
        while (nb[0] - base < 21 && hi < 200) begin
            step();
            hi++;
        end
        chk("abort_bit20_seen", 64'(nb[0] - base), 64'd21);
        rst = 1'b1;
        step();
        chk("abort_outputs", 64'({sd[0], sc[0], sl[0], se[0], fd[0], rdy[0]}), 64'b000101);
        rst = 1'b0;
        repeat (300) step();
        chk("abort_no_done", 64'(ndone[0] - d), 64'd0);
        chk("abort_no_latch", 64'(nlat[0] - l), 64'd0);
        chk("abort_rises", 64'(nb[0] - base), 64'd21);
        chk("abort_partial", 64'(word(0, base, 21)), 64'h04_5566);
        chk("abort_ready", 64'(rdy[0]), 64'd1);
        base = nb[0];
        d = ndone[0];
        load(0, 48'hDEAD_BEEF_0102, 6'd0);
        wait_done("post_abort_timeout", 0, d + 1, 400);
        chk("post_abort_word", 64'(word(0, base, 48)), 64'hDEAD_BEEF_0102);
        chk("post_abort_rises", 64'(nb[0] - base), 64'd48);

        rst_b = 1'b0;
        step();
        load(2, 48'hA5A5_A5A5_A560, 6'b000001);
        wait_done("blink_timeout", 2, 3, 2000);
        chk("blink_f1", 64'(word(2, 0, 48)), 64'hA5A5_A5A5_A560);
        chk("blink_f2_off", 64'(word(2, 48, 48)), 64'hA5A5_A5A5_A500);
        chk("blink_f3_on", 64'(word(2, 96, 48)), 64'hA5A5_A5A5_A560);
        chk("blink_spacing", 64'(rise_cyc[2][96] - rise_cyc[2][48]), 64'd240);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
